// File: rtl/fb_read_arbiter_if.sv
// Read-port bundle between the arbiter, its two requesters and the current-frame framebuffer.
// The slave modport is the arbiter side; the master modport is the requester/framebuffer side.
interface fb_read_arbiter_if #(
    parameter int c_addr_w = 10,
    parameter int c_bpc    = 12
);
    logic                i_drv_req;
    logic [c_addr_w-1:0] i_drv_addr;
    logic                o_drv_gnt;
    logic                o_drv_valid;
    logic [c_bpc-1:0]    o_drv_data;

    logic                i_ani_req;
    logic [c_addr_w-1:0] i_ani_addr;
    logic                o_ani_gnt;
    logic                o_ani_valid;
    logic [c_bpc-1:0]    o_ani_data;

    logic [c_addr_w-1:0] o_fb_raddr;
    logic [c_bpc-1:0]    i_fb_rdata;

    modport slave (
        input  i_drv_req, i_drv_addr, i_ani_req, i_ani_addr, i_fb_rdata,
        output o_drv_gnt, o_drv_valid, o_drv_data,
        output o_ani_gnt, o_ani_valid, o_ani_data, o_fb_raddr
    );

    modport master (
        output i_drv_req, i_drv_addr, i_ani_req, i_ani_addr, i_fb_rdata,
        input  o_drv_gnt, o_drv_valid, o_drv_data,
        input  o_ani_gnt, o_ani_valid, o_ani_data, o_fb_raddr
    );
endinterface

// File: rtl/fb_read_arbiter.sv
// Shares the current-frame framebuffer read port between the LED driver and the animator, tagging each read.
// Optional macro FB_ARB_FAIR_EN: round-robin on contention instead of strict driver priority.
module fb_read_arbiter #(
    parameter int c_ledboards  = 30,
    parameter int c_bpc        = 12,
    parameter int c_rd_latency = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    fb_read_arbiter_if.slave bus,
    input  logic             i_clr_stall,
    output logic [15:0]      o_stall_cnt
);
    localparam int c_channels = c_ledboards * 32;
    localparam int c_addr_w   = $clog2(c_channels);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic drv_win;
    logic ani_win;

`ifdef FB_ARB_FAIR_EN
    // prio_ani: the animator wins the next contended cycle
    logic prio_ani;
    logic contend;
    assign contend = bus.i_drv_req & bus.i_ani_req;

    always_comb begin
        drv_win = bus.i_drv_req;
        ani_win = bus.i_ani_req;
        if (contend) begin
            drv_win = ~prio_ani;
            ani_win = prio_ani;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_ani <= 1'b0;
        end else if (contend) begin
            prio_ani <= ~prio_ani;
        end
    end
`else
    assign drv_win = bus.i_drv_req;
    assign ani_win = bus.i_ani_req & ~bus.i_drv_req;
`endif

    // p0: issue stage, grant pulse and registered framebuffer address
    logic                gnt_drv_p0;
    logic                gnt_ani_p0;
    logic [c_addr_w-1:0] raddr_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_drv_p0 <= 1'b0;
            gnt_ani_p0 <= 1'b0;
            raddr_p0   <= '0;
        end else begin
            gnt_drv_p0 <= drv_win;
            gnt_ani_p0 <= ani_win;
            if (drv_win) begin
                raddr_p0 <= bus.i_drv_addr;
            end else if (ani_win) begin
                raddr_p0 <= bus.i_ani_addr;
            end
        end
    end

    // p1: owner tag {drv,ani} delayed to line up with i_fb_rdata
    logic [1:0] tag_p1 [c_rd_latency];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_rd_latency; i++) begin
                tag_p1[i] <= 2'b00;
            end
        end else begin
            tag_p1[0] <= {gnt_drv_p0, gnt_ani_p0};
            for (int i = 1; i < c_rd_latency; i++) begin
                tag_p1[i] <= tag_p1[i-1];
            end
        end
    end

    // p2: return stage, only the tagged owner captures the data
    logic             vld_drv_p2;
    logic             vld_ani_p2;
    logic [c_bpc-1:0] data_drv_p2;
    logic [c_bpc-1:0] data_ani_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_drv_p2  <= 1'b0;
            vld_ani_p2  <= 1'b0;
            data_drv_p2 <= '0;
            data_ani_p2 <= '0;
        end else begin
            vld_drv_p2 <= tag_p1[c_rd_latency-1][1];
            vld_ani_p2 <= tag_p1[c_rd_latency-1][0];
            if (tag_p1[c_rd_latency-1][1]) begin
                data_drv_p2 <= bus.i_fb_rdata;
            end
            if (tag_p1[c_rd_latency-1][0]) begin
                data_ani_p2 <= bus.i_fb_rdata;
            end
        end
    end

    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= 16'd0;
        end else if (i_clr_stall) begin
            stall_cnt <= 16'd0;
        end else if (bus.i_ani_req && !ani_win) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

    assign bus.o_drv_gnt   = gnt_drv_p0;
    assign bus.o_ani_gnt   = gnt_ani_p0;
    assign bus.o_fb_raddr  = raddr_p0;
    assign bus.o_drv_valid = vld_drv_p2;
    assign bus.o_ani_valid = vld_ani_p2;
    assign bus.o_drv_data  = data_drv_p2;
    assign bus.o_ani_data  = data_ani_p2;
    assign o_stall_cnt     = stall_cnt;
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter: scenario tasks plus randomized traffic against a
// cycle-indexed reference of expected outputs; honours FB_ARB_FAIR_EN when defined.
`timescale 1ns/1ps
module tb_fb_read_arbiter;
    localparam int LB   = 30;
    localparam int BPC  = 12;
    localparam int LAT  = 1;
    localparam int AW   = $clog2(LB * 32);
    localparam int RING = 16;
    localparam int VW   = 4 + AW + 2 * BPC + 16;
`ifdef FB_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_stall = 1'b0;
    logic [15:0] stall_cnt;

    fb_read_arbiter_if #(.c_addr_w(AW), .c_bpc(BPC)) bus ();

    fb_read_arbiter #(.c_ledboards(LB), .c_bpc(BPC), .c_rd_latency(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .i_clr_stall (clr_stall),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // framebuffer model: synchronous read with LAT cycles of latency
    logic [BPC-1:0] mem [1 << AW];
    logic [BPC-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.o_fb_raddr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.i_fb_rdata = rd_pipe[LAT-1];

    // expected outputs per cycle, ring-indexed by cycle number
    logic           e_gd [RING];
    logic           e_ga [RING];
    logic           e_vd [RING];
    logic           e_va [RING];
    logic [AW-1:0]  e_ra [RING];
    logic [BPC-1:0] e_dd [RING];
    logic [BPC-1:0] e_da [RING];
    int             e_st [RING];
    bit             next_ani;
    bit             last_dw, last_aw;
    int             cyc;
    int             checks = 0;
    int             failures = 0;

    task automatic model_reset();
        for (int i = 0; i < RING; i++) begin
            e_gd[i] = 0; e_ga[i] = 0; e_vd[i] = 0; e_va[i] = 0;
            e_ra[i] = '0; e_dd[i] = '0; e_da[i] = '0; e_st[i] = 0;
        end
        next_ani = 0; last_dw = 0; last_aw = 0;
    endtask

    // Applies the arbitration rules to the inputs sampled at the end of cycle c.
    task automatic model_plan(input int c);
        int s = c % RING;
        int n = (c + 1) % RING;
        int r = (c + LAT + 2) % RING;
        bit dr = bus.i_drv_req;
        bit ar = bus.i_ani_req;
        bit dw, aw;
        if (!rst_n) begin
            e_gd[n] = 0; e_ga[n] = 0; e_vd[n] = 0; e_va[n] = 0;
            e_ra[n] = '0; e_dd[n] = '0; e_da[n] = '0; e_st[n] = 0;
            last_dw = 0; last_aw = 0;
        end else begin
            if (dr && ar) begin
                aw = FAIR ? next_ani : 1'b0;
                dw = !aw;
                next_ani = FAIR ? !next_ani : 1'b0;
            end else begin
                dw = dr; aw = ar;
            end
            last_dw = dw; last_aw = aw;
            e_gd[n] = dw;
            e_ga[n] = aw;
            e_ra[n] = dw ? bus.i_drv_addr : (aw ? bus.i_ani_addr : e_ra[s]);
            if (clr_stall)      e_st[n] = 0;
            else if (ar && !aw) e_st[n] = (e_st[s] >= 65535) ? 65535 : e_st[s] + 1;
            else                e_st[n] = e_st[s];
            if (dw) begin e_vd[r] = 1; e_dd[r] = mem[bus.i_drv_addr]; end
            if (aw) begin e_va[r] = 1; e_da[r] = mem[bus.i_ani_addr]; end
            if (!e_vd[n]) e_dd[n] = e_dd[s];
            if (!e_va[n]) e_da[n] = e_da[s];
        end
        e_vd[s] = 0;
        e_va[s] = 0;
    endtask

    task automatic tick();
        model_plan(cyc);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_in(input logic dr, input logic [AW-1:0] da, input logic ar,
                          input logic [AW-1:0] aa, input logic clr);
        bus.i_drv_req = dr; bus.i_drv_addr = da;
        bus.i_ani_req = ar; bus.i_ani_addr = aa;
        clr_stall = clr;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {bus.o_drv_gnt, bus.o_ani_gnt, bus.o_drv_valid, bus.o_ani_valid,
                bus.o_fb_raddr, bus.o_drv_data, bus.o_ani_data, stall_cnt};
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int c);
        int s = c % RING;
        return {e_gd[s], e_ga[s], e_vd[s], e_va[s], e_ra[s], e_dd[s], e_da[s], 16'(e_st[s])};
    endfunction

    task automatic test_reset();
        set_in(0, '0, 0, '0, 0);
        rst_n = 0;
        model_reset();
        cyc = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            tick();
        end
        checks++;
        if (bus.o_fb_raddr !== '0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_zero got raddr=%0d stall=%0d want 0/0", bus.o_fb_raddr, stall_cnt);
        end
        rst_n = 1;
    endtask

    task automatic test_drv_stream();
        int gd = 0, vd = 0, va = 0;
        for (int i = 0; i < 4 + LAT + 5; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL drv_stream cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            gd += int'(bus.o_drv_gnt); vd += int'(bus.o_drv_valid); va += int'(bus.o_ani_valid);
            if (i < 4) set_in(1, AW'(i), 0, '0, 0);
            else       set_in(0, '0, 0, '0, 0);
            tick();
        end
        checks++;
        if (gd !== 4 || vd !== 4 || va !== 0) begin
            failures++;
            $display("FAIL drv_stream_counts got gnt=%0d vld=%0d ani_vld=%0d want 4/4/0", gd, vd, va);
        end
    endtask

    task automatic test_contention();
        int gd = 0, ga = 0;
        for (int i = 0; i < 8 + LAT + 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            gd += int'(bus.o_drv_gnt); ga += int'(bus.o_ani_gnt);
            if (i == 0)     set_in(0, '0, 0, '0, 1);
            else if (i < 7) set_in(1, AW'(5), 1, AW'(9), 0);
            else if (i == 7) set_in(0, '0, 1, AW'(9), 0);
            else            set_in(0, '0, 0, '0, 0);
            tick();
        end
        checks++;
        if (gd !== (FAIR ? 3 : 6) || ga !== (FAIR ? 4 : 1) || stall_cnt !== (FAIR ? 16'd3 : 16'd6)) begin
            failures++;
            $display("FAIL contention_counts got drv=%0d ani=%0d stall=%0d want %0d/%0d/%0d",
                     gd, ga, stall_cnt, FAIR ? 3 : 6, FAIR ? 4 : 1, FAIR ? 3 : 6);
        end
        checks++;
        if (bus.o_ani_data !== mem[9]) begin
            failures++;
            $display("FAIL contention_ani_data got=%h want=%h", bus.o_ani_data, mem[9]);
        end
    endtask

    task automatic test_single_reads();
        int vd = 0, va = 0;
        for (int i = 0; i < 6 + LAT + 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL single_reads cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            vd += int'(bus.o_drv_valid); va += int'(bus.o_ani_valid);
            case (i)
                0:       set_in(1, AW'(10), 0, '0, 0);
                2:       set_in(0, '0, 1, AW'(20), 0);
                4:       set_in(1, AW'(11), 0, '0, 0);
                default: set_in(0, '0, 0, '0, 0);
            endcase
            tick();
        end
        checks++;
        if (vd !== 2 || va !== 1 || bus.o_drv_data !== mem[11] || bus.o_ani_data !== mem[20]) begin
            failures++;
            $display("FAIL single_reads_final got dv=%0d av=%0d dd=%h ad=%h want 2/1/%h/%h",
                     vd, va, bus.o_drv_data, bus.o_ani_data, mem[11], mem[20]);
        end
    endtask

    task automatic test_reset_midflight();
        int va = 0;
        set_in(0, '0, 1, AW'(20), 0);
        tick();
        set_in(0, '0, 0, '0, 0);
        tick();
        tick();
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== {VW{1'b0}}) begin
            failures++;
            $display("FAIL reset_mid_zero got=%h want=0", obs_vec());
        end
        @(negedge clk);
        tick();
        rst_n = 1;
        for (int i = 0; i < LAT + 4; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            va += int'(bus.o_ani_valid);
            tick();
        end
        checks++;
        if (va !== 0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_valid got ani_vld=%0d stall=%0d want 0/0", va, stall_cnt);
        end
    endtask

    task automatic test_random();
        bit pend_d = 0, pend_a = 0;
        logic dr, ar, clr;
        logic [AW-1:0] da, aa;
        dr = 0; ar = 0; da = '0; aa = '0;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
            if (!pend_d) begin dr = 1'($urandom_range(0, 1)); da = AW'($urandom); end
            if (!pend_a) begin ar = 1'($urandom_range(0, 1)); aa = AW'($urandom); end
            clr = ($urandom_range(0, 15) == 0);
            set_in(dr, da, ar, aa, clr);
            tick();
            pend_d = dr && !last_dw;
            pend_a = ar && !last_aw;
        end
        set_in(0, '0, 0, '0, 0);
        for (int i = 0; i < LAT + 3; i++) tick();
        checks++;
        if (obs_vec() !== exp_vec(cyc)) begin
            failures++;
            $display("FAIL random_drain got=%h want=%h", obs_vec(), exp_vec(cyc));
        end
    endtask

    task automatic test_stall_sat();
        set_in(1, AW'(1), 1, AW'(2), 1);
        tick();
        set_in(1, AW'(1), 1, AW'(2), 0);
`ifndef FB_ARB_FAIR_EN
        for (int i = 0; i < 65533; i++) tick();
        checks++;
        if (stall_cnt !== 16'd65533) begin
            failures++;
            $display("FAIL stall_preload got=%0d want=65533", stall_cnt);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL stall_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec(cyc));
            end
        end
        checks++;
        if (stall_cnt !== (FAIR ? 16'd2 : 16'hFFFF)) begin
            failures++;
            $display("FAIL stall_sat got=%h want=%h", stall_cnt, FAIR ? 16'd2 : 16'hFFFF);
        end
        set_in(1, AW'(1), 1, AW'(2), 1);
        tick();
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stall_clear got=%0d want=0", stall_cnt);
        end
        set_in(0, '0, 0, '0, 0);
        for (int i = 0; i < LAT + 3; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = BPC'($urandom);
        test_reset();
        test_drv_stream();
        test_contention();
        test_single_reads();
        test_reset_midflight();
        test_random();
        test_stall_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Arbitrates the single read port of the current-frame framebuffer between two requesters: the LED driver (shift-out) and the animator (read-modify-write of current values).
- Replaces the address-OR sharing of that read port.
- Tags each issued read and returns data only to its owner with a fixed latency.
- Sits between driver/animator and the current framebuffer, in the divided-clock domain.

Parameters:
- c_ledboards, 30, number of LED boards; channels = c_ledboards*32; c_addr_w = $clog2(channels).
- c_bpc, 12, bits per channel (data width).
- c_rd_latency, 1, framebuffer read latency in cycles from o_fb_raddr to i_fb_rdata; legal values 1..3.

Ports:
- i_clk  in  1  divided system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_drv_req  in  1  driver read request.
- i_drv_addr  in  c_addr_w  driver read address; held stable while i_drv_req is high and ungranted.
- o_drv_gnt  out  1  one-cycle pulse: driver request accepted.
- o_drv_valid  out  1  one-cycle pulse: o_drv_data holds the granted read.
- o_drv_data  out  c_bpc  driver read data.
- i_ani_req, i_ani_addr, o_ani_gnt, o_ani_valid, o_ani_data  same as the driver ports, for the animator.
- o_fb_raddr  out  c_addr_w  framebuffer read address (registered).
- i_fb_rdata  in  c_bpc  framebuffer read data.
- i_clr_stall  in  1  synchronous clear of o_stall_cnt.
- o_stall_cnt  out  16  saturating count of cycles the animator request was denied.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; o_fb_raddr=0; tag pipeline cleared; priority pointer set to driver.
- Reset mid-operation: in-flight reads are discarded. No o_*_valid is asserted for reads issued before reset.
- Arbitration, evaluated each cycle on the sampled requests:
  - Neither requesting: idle; o_fb_raddr holds its last value; no grant.
  - One requesting: that requester wins.
  - Both requesting: the driver wins (fixed priority; driver timing is frame-critical).
- Issue: if the request is sampled in cycle N, then on edge N+1 o_fb_raddr <= winner address and the winner's o_*_gnt is high for cycle N+1 only. At most one gnt per cycle.
- Request rule: a req still high during the requester's own gnt cycle counts as a new request with the address present in that cycle. This allows one read per cycle back-to-back. A requester wanting a single read drops req in its gnt cycle.
- Return path:
  - A 2-bit owner tag {drv,ani} is shifted through a c_rd_latency-deep pipeline, aligned with i_fb_rdata.
  - When the tag emerges, the owner's o_*_data <= i_fb_rdata and o_*_valid pulses for 1 cycle.
  - Latency from gnt cycle to valid cycle is exactly c_rd_latency+1 cycles.
  - o_*_data of the non-owner holds its last value.
- Ordering: valids per requester arrive in grant order. No reads are dropped or duplicated.
- Stall counter:
  - Increments on each cycle the animator request was sampled but lost arbitration.
  - Saturates at 16'hFFFF.
  - i_clr_stall=1 forces 0 and takes precedence over an increment in the same cycle.
- Address range: addresses >= channels are passed through unchanged. The arbiter does not check range.

Optional Feature:
- FB_ARB_FAIR_EN
- Defined: round-robin on contention. A 1-bit pointer records the last contended winner, and on the next contention the other requester wins. The pointer updates only on contended cycles; uncontended grants do not touch it. This bounds animator wait to 1 cycle.
- Undefined: strict driver priority as above; the pointer logic is not synthesized.

Test Plan:
- Reset, then only driver streams addr 0,1,2,3 with req held continuously, c_rd_latency=1 → o_drv_gnt high for 4 consecutive cycles; o_fb_raddr=0,1,2,3; o_drv_valid 2 cycles after each gnt with data = fb contents 0..3; o_ani_valid never asserts.
- Both req continuously, driver addr 5, animator addr 9, FB_ARB_FAIR_EN undefined → only the driver is granted; o_stall_cnt increments by 1 per cycle; drop driver req → animator is granted next cycle and reads fb[9].
- Same stimulus with FB_ARB_FAIR_EN defined → grants alternate drv, ani, drv, ani; o_stall_cnt increments only on cycles the animator lost.
- c_rd_latency=3, alternating single reads drv@10, ani@20, drv@11 → each valid is 4 cycles after its gnt, routed to the correct owner with data fb[10], fb[20], fb[11].
- Assert i_rst_n=0 one cycle after an animator gnt with c_rd_latency=2, release after 2 cycles → no o_ani_valid after release; all outputs 0; o_stall_cnt=0.
- Preload o_stall_cnt near 16'hFFFE via sustained contention, continue contention → counter saturates at 16'hFFFF; pulse i_clr_stall together with a contended cycle → counter reads 0.
